// File: rtl/video_pkg.sv
// Shared types and constants for the video test-pattern source.
package video_pkg;

    typedef enum logic [2:0] {
        SOLID   = 3'd0,
        BARS    = 3'd1,
        RAMP    = 3'd2,
        CHECKER = 3'd3,
        MOVBAR  = 3'd4
    } pattern_mode_e;

    // 3-bit RGB code per bar, left to right: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [2:0] BAR_CODE [8] = '{3'd7, 3'd6, 3'd3, 3'd2, 3'd5, 3'd4, 3'd1, 3'd0};

    localparam int unsigned MOVBAR_PERIOD = 64;
    localparam int unsigned MOVBAR_WIDTH  = 16;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Frame/line edge detection, pixel/line/frame counters and timing-geometry checks.
module video_timing_cnt
    import video_pkg::*;
#(
    parameter int unsigned HRES = 320,
    parameter int unsigned VRES = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync_i,
    input  logic        de_i,
    output logic        fs_o,
    output logic [15:0] x_o,
    output logic [15:0] y_o,
    output logic [15:0] frame_cnt_o,
    output logic        err_h_o,
    output logic        err_v_o
);

    logic        vsync_q, de_q;
    logic        first_q, first_d;
    logic        err_h_q, err_h_d;
    logic        err_v_q, err_v_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic [15:0] y_le;
    logic        fs, le;

    assign fs = vsync_q & ~vsync_i;
    assign le = de_q & ~de_i;

    // A line end on the frame-start clock is counted before the line total is checked.
    always_comb begin
        x_d     = x_q;
        y_le    = y_q;
        err_h_d = 1'b0;
        err_v_d = 1'b0;
        fcnt_d  = fcnt_q;
        first_d = first_q;
        if (de_i) begin
            x_d = sat_inc16(x_q);
        end
        if (le) begin
            x_d     = '0;
            err_h_d = (x_q != 16'(HRES));
            y_le    = sat_inc16(y_q);
        end
        y_d = y_le;
        if (fs) begin
            y_d     = '0;
            first_d = 1'b0;
            if (!first_q) begin
                err_v_d = (y_le != 16'(VRES));
                fcnt_d  = fcnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            de_q    <= 1'b0;
            first_q <= 1'b1;
            err_h_q <= 1'b0;
            err_v_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            fcnt_q  <= '0;
        end else begin
            vsync_q <= vsync_i;
            de_q    <= de_i;
            first_q <= first_d;
            err_h_q <= err_h_d;
            err_v_q <= err_v_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign fs_o        = fs;
    assign x_o         = x_q;
    assign y_o         = y_q;
    assign frame_cnt_o = fcnt_q;
    assign err_h_o     = err_h_q;
    assign err_v_o     = err_v_q;

endmodule

// File: rtl/video_pattern_src.sv
// N-channel test-pattern source locked to incoming sync/DE timing, with a
// fixed-latency pipeline and a per-frame mode/colour latch.
module video_pattern_src
    import video_pkg::*;
#(
    parameter int unsigned CH_NUM   = 3,
    parameter int unsigned BPC      = 8,
    parameter int unsigned HRES     = 320,
    parameter int unsigned VRES     = 240,
    parameter int unsigned LATENCY  = 2,
    parameter int unsigned CHK_LOG2 = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               i_mode,
    input  logic [CH_NUM*BPC-1:0]    i_solid,
    input  logic                     i_vsync,
    input  logic                     i_hsync,
    input  logic                     i_de,
    output logic                     o_vsync,
    output logic                     o_hsync,
    output logic                     o_de,
    output logic [CH_NUM*BPC-1:0]    o_data,
    output logic [15:0]              o_frame_cnt,
    output logic                     o_err_h,
    output logic                     o_err_v
);

    localparam int unsigned    DW    = CH_NUM * BPC;
    localparam int unsigned    BAR_W = HRES / 8;
    localparam logic [BPC-1:0] MAX   = '1;

    logic        fs;
    logic [15:0] x_cur, y_cur, fcnt;

    video_timing_cnt #(
        .HRES (HRES),
        .VRES (VRES)
    ) u_timing_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .vsync_i     (i_vsync),
        .de_i        (i_de),
        .fs_o        (fs),
        .x_o         (x_cur),
        .y_o         (y_cur),
        .frame_cnt_o (fcnt),
        .err_h_o     (o_err_h),
        .err_v_o     (o_err_v)
    );

    assign o_frame_cnt = fcnt;

    logic [2:0]    mode_q;
    logic [DW-1:0] solid_q;
    logic [15:0]   x_p1, y_p1;
    logic          vld_p1, vs_p1, hs_p1;
    logic [DW-1:0] data_p2;
    logic          vld_p2, vs_p2, hs_p2;
    logic          unused_y_bits;

    // Only the checker bit of the line index feeds the pattern.
    assign unused_y_bits = ^y_p1;

    function automatic logic [DW-1:0] fill(input logic on);
        return on ? {CH_NUM{MAX}} : '0;
    endfunction

    function automatic logic [DW-1:0] pattern(input logic [2:0]    mode,
                                              input logic [DW-1:0] solid,
                                              input logic [15:0]   x,
                                              input logic          y_chk,
                                              input logic [15:0]   fc);
        logic [DW-1:0] px;
        logic [15:0]   bar_idx;
        logic [2:0]    bar_sel;
        logic [2:0]    code;
        logic [15:0]   dx;
        px      = '0;
        bar_idx = '0;
        bar_sel = '0;
        code    = '0;
        dx      = '0;
        case (pattern_mode_e'(mode))
            SOLID:   px = solid;
            BARS: begin
                bar_idx = x / 16'(BAR_W);
                bar_sel = (bar_idx > 16'd7) ? 3'd7 : bar_idx[2:0];
                code    = BAR_CODE[bar_sel];
                for (int c = 0; c < int'(CH_NUM); c++) begin
                    px[(int'(CH_NUM) - 1 - c) * int'(BPC) +: BPC] = code[2 - (c % 3)] ? MAX : '0;
                end
            end
            RAMP:    px = {CH_NUM{x[BPC-1:0]}};
            CHECKER: px = fill(x[CHK_LOG2] ^ y_chk);
            MOVBAR: begin
                dx = x - fc;
                px = fill((dx % 16'(MOVBAR_PERIOD)) < 16'(MOVBAR_WIDTH));
            end
            default: px = '0;
        endcase
        return px;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= '0;
            solid_q <= '0;
            x_p1    <= '0;
            y_p1    <= '0;
            vld_p1  <= 1'b0;
            vs_p1   <= 1'b0;
            hs_p1   <= 1'b0;
            data_p2 <= '0;
            vld_p2  <= 1'b0;
            vs_p2   <= 1'b0;
            hs_p2   <= 1'b0;
        end else begin
            if (fs) begin
                mode_q  <= i_mode;
                solid_q <= i_solid;
            end
            // stage 1: capture position and timing
            x_p1   <= x_cur;
            y_p1   <= y_cur;
            vld_p1 <= i_de;
            vs_p1  <= i_vsync;
            hs_p1  <= i_hsync;
            // stage 2: pattern pixel, forced to 0 outside active video
            data_p2 <= vld_p1 ? pattern(mode_q, solid_q, x_p1, y_p1[CHK_LOG2], fcnt) : '0;
            vld_p2  <= vld_p1;
            vs_p2   <= vs_p1;
            hs_p2   <= hs_p1;
        end
    end

    generate
        if (LATENCY > 2) begin : g_dly
            localparam int unsigned D = LATENCY - 2;
            logic [DW+2:0] dly_q [D];

            // stages 3..LATENCY: plain delay line
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(D); i++) dly_q[i] <= '0;
                end else begin
                    dly_q[0] <= {vs_p2, hs_p2, vld_p2, data_p2};
                    for (int i = 1; i < int'(D); i++) dly_q[i] <= dly_q[i-1];
                end
            end

            assign {o_vsync, o_hsync, o_de, o_data} = dly_q[D-1];
        end else begin : g_nodly
            assign {o_vsync, o_hsync, o_de, o_data} = {vs_p2, hs_p2, vld_p2, data_p2};
        end
    endgenerate

endmodule

// File: tb/tb_video_pattern_src.sv
// Randomised bench for video_pattern_src against a frame-level reference model.
module tb_video_pattern_src;

    localparam int HRES     = 16;
    localparam int VRES     = 4;
    localparam int BPC      = 8;
    localparam int CH_NUM   = 3;
    localparam int LATENCY  = 2;
    localparam int CHK_LOG2 = 1;

    localparam logic [23:0] BAR_RGB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  i_mode = '0;
    logic [23:0] i_solid = '0;
    logic        i_vsync = 1'b0, i_hsync = 1'b0, i_de = 1'b0;
    logic        o_vsync, o_hsync, o_de;
    logic [23:0] o_data;
    logic [15:0] o_frame_cnt;
    logic        o_err_h, o_err_v;

    always #5 clk = ~clk;

    video_pattern_src #(
        .CH_NUM   (CH_NUM),
        .BPC      (BPC),
        .HRES     (HRES),
        .VRES     (VRES),
        .LATENCY  (LATENCY),
        .CHK_LOG2 (CHK_LOG2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mode      (i_mode),
        .i_solid     (i_solid),
        .i_vsync     (i_vsync),
        .i_hsync     (i_hsync),
        .i_de        (i_de),
        .o_vsync     (o_vsync),
        .o_hsync     (o_hsync),
        .o_de        (o_de),
        .o_data      (o_data),
        .o_frame_cnt (o_frame_cnt),
        .o_err_h     (o_err_h),
        .o_err_v     (o_err_v)
    );

    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        de;
        logic [23:0] data;
    } exp_t;

    exp_t        expq[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          fc_m;
    bit          first_m;
    int          prev_lines_m;
    int          mode_m;
    logic [23:0] solid_m;
    int          lens_g [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [23:0] model_pixel(input int mode, input logic [23:0] solid,
                                                input int x, input int y, input int fc);
        int bar;
        logic [23:0] px;
        px = '0;
        case (mode)
            0: px = solid;
            1: begin
                bar = x / (HRES / 8);
                if (bar > 7) bar = 7;
                px = BAR_RGB[bar];
            end
            2: px = 24'((x % 256) * 32'h010101);
            3: px = ((((x >> CHK_LOG2) + (y >> CHK_LOG2)) % 2) == 1) ? 24'hFFFFFF : 24'h0;
            4: px = ((((x - fc) % 64) + 64) % 64 < 16) ? 24'hFFFFFF : 24'h0;
            default: px = '0;
        endcase
        return px;
    endfunction

    task automatic model_reset();
        fc_m         = 0;
        first_m      = 1'b1;
        prev_lines_m = 0;
        mode_m       = 0;
        solid_m      = '0;
        expq.delete();
        expq.push_back('0);
    endtask

    // Apply one clock of input; check the outputs produced by the previous clock's input.
    task automatic tick(input logic vs, input logic hs, input logic de, input logic [23:0] px,
                        input logic eh, input logic ev);
        exp_t e;
        i_vsync = vs;
        i_hsync = hs;
        i_de    = de;
        e.vs    = vs;
        e.hs    = hs;
        e.de    = de;
        e.data  = de ? px : 24'h0;
        expq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = expq.pop_front();
        check("o_vsync", 32'(o_vsync), 32'(e.vs));
        check("o_hsync", 32'(o_hsync), 32'(e.hs));
        check("o_de", 32'(o_de), 32'(e.de));
        check("o_data", 32'(o_data), 32'(e.data));
        check("o_err_h", 32'(o_err_h), 32'(eh));
        check("o_err_v", 32'(o_err_v), 32'(ev));
        check("o_frame_cnt", 32'(o_frame_cnt), fc_m);
    endtask

    task automatic frame_start(input int mode, input logic [23:0] solid);
        logic ev;
        i_mode  = 3'(mode);
        i_solid = solid;
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        ev = !first_m && (prev_lines_m != VRES);
        if (!first_m) fc_m = (fc_m + 1) % 65536;
        first_m = 1'b0;
        mode_m  = mode;
        solid_m = solid;
        tick(1'b0, 1'b0, 1'b0, '0, 1'b0, ev);
    endtask

    task automatic send_frame(input int mode, input logic [23:0] solid, input int nlines,
                              input bit chg_solid, input logic [23:0] solid2, input bit chg_mode);
        int len;
        frame_start(mode, solid);
        for (int l = 0; l < nlines; l++) begin
            len = lens_g[l];
            if (chg_solid && l == 1) i_solid = solid2;
            tick(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
            for (int x = 0; x < len; x++)
                tick(1'b0, 1'b0, 1'b1, model_pixel(mode_m, solid_m, x, l, fc_m), 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b0, '0, logic'(len != HRES), 1'b0);
            if (chg_mode) i_mode = 3'($urandom_range(0, 7));
        end
        prev_lines_m = nlines;
    endtask

    task automatic fill_lens(input int v);
        for (int i = 0; i < 8; i++) lens_g[i] = v;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_o_de", 32'(o_de), 32'd0);
        check("rst_o_data", 32'(o_data), 32'd0);
        check("rst_o_frame_cnt", 32'(o_frame_cnt), 32'd0);
        check("rst_o_err_v", 32'(o_err_v), 32'd0);
        rst_n = 1'b1;

        // Reset asserted mid-line at x=5 while i_de is high.
        tick(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int x = 0; x < 5; x++) tick(1'b0, 1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
        i_de = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_o_de", 32'(o_de), 32'd0);
        check("midrst_o_data", 32'(o_data), 32'd0);
        check("midrst_o_hsync", 32'(o_hsync), 32'd0);
        check("midrst_o_frame_cnt", 32'(o_frame_cnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        i_de  = 1'b0;
        rst_n = 1'b1;
        model_reset();

        // Moving bar over three frames, then the fixed scenarios.
        fill_lens(HRES);
        for (int f = 0; f < 3; f++) send_frame(4, 24'h0, VRES, 1'b0, 24'h0, 1'b0);
        send_frame(1, 24'h0, VRES, 1'b0, 24'h0, 1'b0);
        send_frame(3, 24'h0, VRES, 1'b0, 24'h0, 1'b0);
        lens_g[1] = HRES - 1;
        send_frame(2, 24'h0, 3, 1'b0, 24'h0, 1'b0);
        fill_lens(HRES);
        send_frame(0, 24'h123456, VRES, 1'b1, 24'hABCDEF, 1'b0);
        send_frame(0, 24'hABCDEF, VRES, 1'b0, 24'h0, 1'b0);

        // Random modes, colours, line counts and line lengths with mid-frame input changes.
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 8; i++) lens_g[i] = $urandom_range(HRES - 2, HRES + 2);
            send_frame($urandom_range(0, 7), 24'($urandom), $urandom_range(3, 5),
                       1'($urandom_range(0, 1)), 24'($urandom), 1'b1);
        end
        frame_start(0, 24'h0);
        tick(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/video_pattern_src.md
Name: video_pattern_src

Overview:
- Parametrised, synthesizable successor to our frame-file pixel source.
- Generates an N-channel test pattern aligned to incoming vsync/hsync/de timing, selected by a mode input.
- Delays the timing signals by a fixed pipeline latency.
- Sits between the timing generator and the display/capture path, and also checks the incoming timing geometry against the expected resolution.

Parameters:
- CH_NUM, 3, number of colour channels; channel 0 occupies the MSBs of o_data.
- BPC, 8, bits per channel.
- HRES, 320, expected active pixels per line (≥ 8).
- VRES, 240, expected active lines per frame.
- LATENCY, 2, input-to-output delay in clocks (≥ 2).
- CHK_LOG2, 4, checkerboard square size is 2^CHK_LOG2 pixels.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- i_mode  in  3  pattern select; sampled at frame start.
- i_solid  in  CH_NUM*BPC  colour for solid mode; sampled at frame start.
- i_vsync  in  1  active-high vsync pulse; its falling edge is frame start.
- i_hsync  in  1  hsync, passed through only.
- i_de  in  1  active-pixel enable.
- o_vsync  out  1  i_vsync delayed LATENCY clocks.
- o_hsync  out  1  i_hsync delayed LATENCY clocks.
- o_de  out  1  i_de delayed LATENCY clocks.
- o_data  out  CH_NUM*BPC  pattern pixel; 0 whenever o_de=0.
- o_frame_cnt  out  16  completed-frame counter; wraps at 0xFFFF→0.
- o_err_h  out  1  1-clk pulse: the line just ended had length ≠ HRES.
- o_err_v  out  1  1-clk pulse at frame start: previous frame line count ≠ VRES.

Behaviour:
- Reset: all outputs 0, all counters 0, latched mode = 0, latched solid = 0.
- Reset is asynchronous in any state; the first frame after reset skips the o_err_v check.
- Edge detection uses registered copies of i_vsync and i_de.
  - Frame start (FS): vsync_q=1 & i_vsync=0.
  - Line end (LE): de_q=1 & i_de=0.
- Counters (16-bit x, y):
  - x increments on each i_de=1 clock, starting at 0 per line.
  - x is cleared on LE; at LE, o_err_h pulses if x ≠ HRES.
  - y increments on LE.
  - On FS: y is cleared; o_err_v pulses if y ≠ VRES and not the first frame; o_frame_cnt increments (except on the first FS after reset); mode and solid are latched.
  - FS and LE on the same clock: LE is processed first (y+1), then the FS compare/clear.
  - Counters saturate at 0xFFFF.
- Pixel pattern is a function of (x, y, latched mode, o_frame_cnt). MAX = 2^BPC-1.
  - Mode 0, solid: latched i_solid.
  - Mode 1, colour bars:
    - bar = min(x / (HRES/8), 7).
    - code[bar] = {7,6,3,2,5,4,1,0} (white, yellow, cyan, green, magenta, red, blue, black).
    - Channel c = MAX if bit (2 − c mod 3) of code is set, else 0.
  - Mode 2, ramp: every channel = x[BPC-1:0] (wraps every 2^BPC pixels).
  - Mode 3, checker: every channel = MAX if (x[CHK_LOG2] ^ y[CHK_LOG2]), else 0.
  - Mode 4, moving bar: every channel = MAX if ((x − o_frame_cnt) mod 64) < 16, else 0.
  - Modes 5–7: all channels 0.
- Pipeline timing:
  - Stage 1 registers x, y, de, vsync and hsync.
  - Stage 2 computes and registers the pattern.
  - Stages 3..LATENCY are a plain delay line.
  - o_data for input pixel k appears together with the o_de cycle corresponding to i_de of pixel k.
- Changes to i_mode or i_solid mid-frame have no effect until the next FS.

Decomposition:
- Package video_pkg:
  - pattern_mode_e enum (SOLID, BARS, RAMP, CHECKER, MOVBAR).
  - BAR_CODE constant array.
  - MOVBAR_PERIOD = 64, MOVBAR_WIDTH = 16.
- Sub-module video_timing_cnt:
  - Edge detect, x/y/frame counters, o_err_h/o_err_v, first-frame flag.
  - Parameterised by HRES and VRES.
- Top level holds the mode/solid latch, pattern logic and delay line.

Test Plan (bench: HRES=16, VRES=4, BPC=8, CH_NUM=3, LATENCY=2):
- Reset mid-line (rst_n low while i_de=1 at x=5) → all outputs 0 immediately; after release, the first FS does not pulse o_err_v, and o_frame_cnt stays 0.
- Mode 1, 16×4 frame → each line's o_data pairs: FFFFFF,FFFFFF, FFFF00,FFFF00, 00FFFF,00FFFF, 00FF00,00FF00, FF00FF,FF00FF, FF0000,FF0000, 0000FF,0000FF, 000000,000000; o_de is i_de delayed exactly 2 clocks.
- Mode 3 with CHK_LOG2=1 → line 0 = 000000,000000,FFFFFF,FFFFFF,…; line 2 inverted; o_data=0 during blanking.
- Line with 15 de clocks → o_err_h pulses 1 clock at that LE; a frame with 3 lines → o_err_v pulses at the next FS; o_frame_cnt increments every FS.
- Mode 0 with i_solid=123456, changed to ABCDEF mid-frame → remainder of the frame is 123456; next frame is ABCDEF.
- Mode 4 across 3 frames → the white span starts at x=0, 1, 2 respectively; x≥16 (mod 64) spans are 0.
